// File: rtl/pcie_os_tx_if.sv
// pcie_os_tx_if: request/response bundle of the PCIe ordered-set transmitter.
//
// master modport (link-training logic driving the transmitter):
//   out OsReq, OsType, LinkNum, LinkNumPad, LaneNumPad, NFts, RateId, TrainCtl
//   in  OsAck, Busy, ElecIdle, LinkOut
// slave modport (pcie_os_tx): the same signals with directions reversed.
//
// LinkOut carries lane n in bits [10n+9:10n]; ElecIdle is one bit per lane.
interface pcie_os_tx_if #(
  parameter int NUM_LANES = 1
);
  logic                      OsReq;
  logic [1:0]                OsType;
  logic [7:0]                LinkNum;
  logic                      LinkNumPad;
  logic                      LaneNumPad;
  logic [7:0]                NFts;
  logic [7:0]                RateId;
  logic [7:0]                TrainCtl;
  logic                      OsAck;
  logic                      Busy;
  logic [NUM_LANES-1:0]      ElecIdle;
  logic [NUM_LANES*10-1:0]   LinkOut;

  modport master (
    output OsReq, OsType, LinkNum, LinkNumPad, LaneNumPad, NFts, RateId, TrainCtl,
    input  OsAck, Busy, ElecIdle, LinkOut
  );

  modport slave (
    input  OsReq, OsType, LinkNum, LinkNumPad, LaneNumPad, NFts, RateId, TrainCtl,
    output OsAck, Busy, ElecIdle, LinkOut
  );
endinterface

// File: rtl/pcie_os_tx.sv
// pcie_os_tx: multi-lane PCIe ordered-set transmitter (TS1, TS2, SKP, EIOS).
//
// Ports:
//   Clk    in  clock, rising edge
//   Reset  in  asynchronous active-high reset
//   os     pcie_os_tx_if.slave
//            OsReq/OsType/LinkNum/LinkNumPad/LaneNumPad/NFts/RateId/TrainCtl in
//            OsAck (one-cycle accept pulse), Busy, ElecIdle[NUM_LANES],
//            LinkOut[NUM_LANES*10] out (lane n at [10n+9:10n])
//
// Compile-time option PCIE_OS_TX_8B10B_EN:
//   defined   - each lane emits an 8b/10b code (bit 0 = a), own running disparity
//   undefined - each lane emits {1'b0, K, D[7:0]}, no disparity logic
//
// All outputs are registered; the request and its fields only reach the
// D side of the output registers.
module pcie_os_tx #(
  parameter int NUM_LANES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  pcie_os_tx_if.slave os
);

  // state | meaning
  // EIDLE | electrical idle: LinkOut = 0, ElecIdle = 1, disparity held at RD-
  // IDLE  | logical idle: D0.0 on every lane
  // SEND  | ordered set in flight, symIdx = index of the symbol on LinkOut
  localparam logic [1:0] EIDLE = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;

  localparam logic [1:0] OS_TS1  = 2'd0;
  localparam logic [1:0] OS_TS2  = 2'd1;
  localparam logic [1:0] OS_SKP  = 2'd2;
  localparam logic [1:0] OS_EIOS = 2'd3;

  localparam logic [7:0] SYM_COM = 8'hBC;  // K28.5
  localparam logic [7:0] SYM_SKP = 8'h1C;  // K28.0
  localparam logic [7:0] SYM_EIE = 8'h7C;  // K28.3
  localparam logic [7:0] SYM_PAD = 8'hF7;  // K23.7
  localparam logic [7:0] ID_TS1  = 8'h4A;  // D10.2
  localparam logic [7:0] ID_TS2  = 8'h45;  // D5.2

  logic [1:0] state, stateNext;
  logic [3:0] symIdx, symIdxNext;

  logic [1:0] osTypeQ;
  logic [7:0] linkNumQ, nFtsQ, rateIdQ, trainCtlQ;
  logic       linkPadQ, lanePadQ;

  logic isTs, lastSym, accept;

  logic [NUM_LANES-1:0][7:0] symByte;
  logic [NUM_LANES-1:0]      symK;
  logic [NUM_LANES-1:0][9:0] codeNext;

  logic [NUM_LANES-1:0][9:0] linkOutQ;
  logic [NUM_LANES-1:0]      elecIdleQ;
  logic                      osAckQ, busyQ;

  // Symbol idx (1..15) of an ordered set for one lane; returns {K, byte}.
  function automatic logic [8:0] setSymbol(
    input logic [1:0] osType,
    input logic [3:0] idx,
    input logic [7:0] laneNum,
    input logic       linkPad,
    input logic       lanePad,
    input logic [7:0] linkNum,
    input logic [7:0] nFts,
    input logic [7:0] rateId,
    input logic [7:0] trainCtl
  );
    logic [8:0] s;
    s = {1'b1, SYM_COM};
    if (idx != 4'd0) begin
      case (osType)
        OS_SKP:  s = {1'b1, SYM_SKP};
        OS_EIOS: s = {1'b1, SYM_EIE};
        default: begin
          case (idx)
            4'd1:    s = linkPad ? {1'b1, SYM_PAD} : {1'b0, linkNum};
            4'd2:    s = lanePad ? {1'b1, SYM_PAD} : {1'b0, laneNum};
            4'd3:    s = {1'b0, nFts};
            4'd4:    s = {1'b0, rateId};
            4'd5:    s = {1'b0, trainCtl};
            default: s = {1'b0, (osType == OS_TS1) ? ID_TS1 : ID_TS2};
          endcase
        end
      endcase
    end
    return s;
  endfunction

  always_comb begin
    isTs    = (osTypeQ == OS_TS1) || (osTypeQ == OS_TS2);
    lastSym = (symIdx == (isTs ? 4'd15 : 4'd3));
    // A held request chains directly onto the last symbol of the current set.
    accept  = os.OsReq && ((state != SEND) || lastSym);
  end

  always_comb begin
    stateNext  = state;
    symIdxNext = symIdx;
    symByte    = '0;
    symK       = '0;
    if (accept) begin
      stateNext  = SEND;
      symIdxNext = 4'd0;
      for (int n = 0; n < NUM_LANES; n++) begin
        symByte[n] = SYM_COM;
        symK[n]    = 1'b1;
      end
    end else begin
      case (state)
        SEND: begin
          if (!lastSym) begin
            symIdxNext = symIdx + 4'd1;
            for (int n = 0; n < NUM_LANES; n++) begin
              {symK[n], symByte[n]} = setSymbol(osTypeQ, symIdxNext, 8'(n),
                                                linkPadQ, lanePadQ, linkNumQ,
                                                nFtsQ, rateIdQ, trainCtlQ);
            end
          end else if (osTypeQ == OS_EIOS) begin
            stateNext = EIDLE;
          end else begin
            stateNext = IDLE;
          end
        end
        IDLE:    stateNext = IDLE;
        default: stateNext = EIDLE;
      endcase
    end
  end

`ifdef PCIE_OS_TX_8B10B_EN
  // Returns {rdOut, code}; code bit 0 is 'a', the first bit on the wire.
  function automatic logic [10:0] encode8b10b(
    input logic [7:0] dIn,
    input logic       kIn,
    input logic       rdIn
  );
    logic [5:0] abcdei;
    logic [3:0] fghj;
    logic [4:0] x;
    logic       rdMid, rdOut, alt7;
    logic [9:0] aToJ, code;
    x = dIn[4:0];
    case (x)
      5'd0:  abcdei = 6'b100111;  5'd1:  abcdei = 6'b011101;
      5'd2:  abcdei = 6'b101101;  5'd3:  abcdei = 6'b110001;
      5'd4:  abcdei = 6'b110101;  5'd5:  abcdei = 6'b101001;
      5'd6:  abcdei = 6'b011001;  5'd7:  abcdei = 6'b111000;
      5'd8:  abcdei = 6'b111001;  5'd9:  abcdei = 6'b100101;
      5'd10: abcdei = 6'b010101;  5'd11: abcdei = 6'b110100;
      5'd12: abcdei = 6'b001101;  5'd13: abcdei = 6'b101100;
      5'd14: abcdei = 6'b011100;  5'd15: abcdei = 6'b010111;
      5'd16: abcdei = 6'b011011;  5'd17: abcdei = 6'b100011;
      5'd18: abcdei = 6'b010011;  5'd19: abcdei = 6'b110010;
      5'd20: abcdei = 6'b001011;  5'd21: abcdei = 6'b101010;
      5'd22: abcdei = 6'b011010;  5'd23: abcdei = 6'b111010;
      5'd24: abcdei = 6'b110011;  5'd25: abcdei = 6'b100110;
      5'd26: abcdei = 6'b010110;  5'd27: abcdei = 6'b110110;
      5'd28: abcdei = 6'b001110;  5'd29: abcdei = 6'b101110;
      5'd30: abcdei = 6'b011110;  default: abcdei = 6'b101011;
    endcase
    if (kIn && (x == 5'd28)) abcdei = 6'b001111;
    // Table holds the RD- form; D.7 is balanced but still has a distinct RD+ form.
    if (rdIn && (($countones(abcdei) != 3) || (abcdei == 6'b111000))) abcdei = ~abcdei;
    rdMid = rdIn ^ ($countones(abcdei) != 3);

    // Alternate D.x.7 avoids a run of five equal bits across the sub-block edge.
    alt7 = kIn || (!rdMid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20)))
               || (rdMid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
    case (dIn[7:5])
      3'd0:    fghj = 4'b1011;
      3'd1:    fghj = 4'b1001;
      3'd2:    fghj = 4'b0101;
      3'd3:    fghj = 4'b1100;
      3'd4:    fghj = 4'b1101;
      3'd5:    fghj = 4'b1010;
      3'd6:    fghj = 4'b0110;
      default: fghj = alt7 ? 4'b0111 : 4'b1110;
    endcase
    if (rdMid && (($countones(fghj) != 2) || (fghj == 4'b1100))) fghj = ~fghj;
    rdOut = rdMid ^ ($countones(fghj) != 2);

    aToJ = {abcdei, fghj};
    for (int i = 0; i < 10; i++) code[i] = aToJ[9-i];
    return {rdOut, code};
  endfunction

  logic [NUM_LANES-1:0] rdQ, rdNext;

  always_comb begin
    rdNext   = '0;
    codeNext = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      {rdNext[n], codeNext[n]} = encode8b10b(symByte[n], symK[n], rdQ[n]);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rdQ <= '0;
    end else if (stateNext == EIDLE) begin
      rdQ <= '0;
    end else begin
      rdQ <= rdNext;
    end
  end
`else
  always_comb begin
    codeNext = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      codeNext[n] = {1'b0, symK[n], symByte[n]};
    end
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= EIDLE;
      symIdx    <= 4'd0;
      osTypeQ   <= OS_TS1;
      linkNumQ  <= 8'h00;
      nFtsQ     <= 8'h00;
      rateIdQ   <= 8'h00;
      trainCtlQ <= 8'h00;
      linkPadQ  <= 1'b0;
      lanePadQ  <= 1'b0;
      linkOutQ  <= '0;
      elecIdleQ <= '1;
      osAckQ    <= 1'b0;
      busyQ     <= 1'b0;
    end else begin
      state  <= stateNext;
      symIdx <= symIdxNext;
      osAckQ <= accept;
      busyQ  <= (stateNext == SEND);
      if (accept) begin
        osTypeQ   <= os.OsType;
        linkNumQ  <= os.LinkNum;
        nFtsQ     <= os.NFts;
        rateIdQ   <= os.RateId;
        trainCtlQ <= os.TrainCtl;
        linkPadQ  <= os.LinkNumPad;
        lanePadQ  <= os.LaneNumPad;
      end
      if (stateNext == EIDLE) begin
        linkOutQ  <= '0;
        elecIdleQ <= '1;
      end else begin
        linkOutQ  <= codeNext;
        elecIdleQ <= '0;
      end
    end
  end

  assign os.OsAck    = osAckQ;
  assign os.Busy     = busyQ;
  assign os.ElecIdle = elecIdleQ;
  assign os.LinkOut  = linkOutQ;

endmodule

// File: doc/pcie_os_tx.md
# pcie_os_tx

Multi-lane PCIe physical-layer ordered-set transmitter: the symbol-generating end of the lane interface consumed by the link monitors and by `PcieVhost` lane inputs. On request it emits TS1, TS2, SKP or EIOS ordered sets on every lane, with a per-lane lane-number field. Between sets it emits logical idle, and after EIOS it holds electrical idle. Output uses the standard 10-bit lane format, with 8b/10b encoding on or off at compile time.

## Interface
- `NUM_LANES`, 1: active lanes, 1..16.
- `Clk`  in  1: clock; all state changes on rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `OsReq`  in  1: request valid; held until `OsAck`.
- `OsType`  in  2: 0=TS1, 1=TS2, 2=SKP, 3=EIOS; sampled at acceptance.
- `LinkNum`  in  8: TS link-number field; sampled at acceptance.
- `LinkNumPad`  in  1: 1 sends PAD (K23.7, 8'hF7) in place of the link number.
- `LaneNumPad`  in  1: 1 sends PAD in place of the lane number.
- `NFts`  in  8: TS N_FTS field.
- `RateId`  in  8: TS rate field.
- `TrainCtl`  in  8: TS training-control field.
- `OsAck`  out  1: one-cycle pulse; request accepted.
- `Busy`  out  1: high while an ordered set is in flight.
- `ElecIdle`  out  NUM_LANES: per-lane electrical idle (all bits equal).
- `LinkOut`  out  NUM_LANES*10: lane n occupies [10n+9:10n].

## Operation
- States: `EIDLE`, `IDLE`, `SEND`. Reset enters `EIDLE`.
- **Symbol count L:** TS1/TS2 sets are 16 symbols; SKP and EIOS sets are 4 symbols.
- **Acceptance:** a request is accepted when `OsReq`=1 and either the state is `EIDLE`/`IDLE`, or the state is `SEND` with the last symbol (index L-1) currently on `LinkOut`.
  - All fields are latched on acceptance.
  - `OsAck` and symbol 0 are registered on the same edge.
- **TS1/TS2 symbol sequence:**
  - 0: COM (K28.5, BC).
  - 1: link number or PAD.
  - 2: lane index n or PAD.
  - 3: N_FTS.
  - 4: rate.
  - 5: training control.
  - 6..15: identifier, 4A (D10.2) for TS1 or 45 (D5.2) for TS2.
- **SKP:** COM followed by 3× K28.0 (1C).
- **EIOS:** COM followed by 3× K28.3 (7C).
- **Transitions:**
  - After SKP or TS: `SEND` → `IDLE` if no request is pending.
  - After EIOS: `SEND` → `EIDLE` if no request is pending.
- **`IDLE`:** D0.0 (data 00) on all lanes every cycle.
- **`EIDLE`:**
  - `LinkOut`=0 and `ElecIdle`=all ones.
  - Running disparity of every lane is forced to RD-.
  - A request clears `ElecIdle` on the edge that registers COM.
- **`Busy`:** 1 in `SEND`, including the acceptance edge; otherwise 0.
- **Reset mid-set:** the set is aborted immediately with no completion.
- `OsReq` deasserted before ack is legal; nothing is sent.

## Timing
- Reset values: `LinkOut`=0, `ElecIdle`=all ones, `OsAck`=0, `Busy`=0, state `EIDLE`, every lane RD-.
- Accept at edge E: `OsAck`=1 and COM on `LinkOut` after E; symbol k appears after edge E+k.
- Back-to-back requests: the next COM follows edge E+L, with no gap symbol.
- `LinkOut` and `ElecIdle` are registered outputs. The only combinational path is `OsReq`/fields → output register D.
- Encoded mode: each lane keeps its own running disparity, updated every emitted symbol except in `EIDLE`.

## Configuration
- `PCIE_OS_TX_8B10B_EN` defined: each lane outputs an 8b/10b code with bit 0 = a (first transmitted), bit 9 = j.
  - Example: K28.5 is 10'h17C at RD- and 10'h283 at RD+.
- `PCIE_OS_TX_8B10B_EN` undefined: each lane outputs {1'b0, K, D[7:0]}, the raw format used when 8b/10b is disabled.
  - Disparity logic is absent.
  - Example: COM = 10'h1BC, D0.0 = 10'h000.

## Test plan
- Reset, then request SKP on 4 lanes (raw mode) → `OsAck` one cycle; every lane shows 1BC, 11C, 11C, 11C, then 000 idle; `ElecIdle` drops on the COM edge.
- TS1 with LinkNum=8'h05, pads=0, NFts=8'h20, RateId=8'h02, TrainCtl=0, 4 lanes (raw) → lane n shows 1BC, 005, n, 020, 002, 000, then 10×04A; 16 cycles of `Busy`.
- TS2 with LinkNumPad=1 and LaneNumPad=1, `OsReq` held → lanes 1/2 = 1F7, ids 045; second TS2 COM directly after symbol 15; exactly 2 `OsAck` pulses.
- EIOS with no further request → 1BC, 17C×3, then `LinkOut`=0 and `ElecIdle`=all ones until the next request.
- Encoded mode: SKP after reset → first COM = 10'h17C on each lane; subsequent symbols match a reference 8b/10b model including RD alternation.
- `Reset` pulsed at TS1 symbol 7 → outputs return to reset values asynchronously; next request starts with COM at RD-.
